rr_decoder_arbiter: RTL
=======================

// Module: rr_decoder_arbiter
// PURPOSE
//  8-way round-robin arbiter sharing one downstream resource between 8 requesters.
//  Selects one requester, registers its 3-bit index, and drives a one-hot grant
//  from that index through a decoder_3x8 instance (A=index, E=grant valid).
//  Holds each grant until the owner signals done, drops its request, or times out.
//  Sits between requester ports and the shared datapath select/enable lines.
// PARAMETERS
//  N_REQ     8   number of requesters; fixed to 8 because the decoder is 3x8
//  IDX_W     3   index width, equal to log2(N_REQ)
//  MAX_HOLD  12  maximum grant length in cycles, legal range 1..15
//  CNT_W     4   hold-counter width
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  req        in   8      request level per requester; held until served
//  done       in   1      1-cycle pulse from the current owner: release grant
//  gnt        out  8      one-hot grant; all zeros when no grant is active
//  gnt_idx    out  3      registered index of the current or last owner
//  gnt_valid  out  1      grant active (this is E of the decoder)
//  timeout    out  1      1-cycle pulse: grant was revoked at MAX_HOLD
//  busy       out  1      FSM is not in IDLE
// BEHAVIOUR
//  Reset: asynchronous on rst_n=0.
//   - gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, busy=0.
//   - FSM=IDLE, hold_cnt=0, last_idx=7, so requester 0 has first priority.
//  FSM states: IDLE, GRANT, REL.
//  IDLE:
//   - If req!=0, pick the first set req bit scanning last_idx+1, +2, ... mod 8.
//   - Register it into gnt_idx, clear hold_cnt, and go to GRANT.
//   - If req==0, stay in IDLE; gnt_idx keeps its old value.
//  Latency: req sampled in cycle t gives gnt_valid=1 and gnt=1<<idx in cycle t+1.
//  GRANT:
//   - gnt_valid=1 and busy=1.
//   - hold_cnt increments each cycle and saturates; it never wraps.
//  GRANT exit conditions, evaluated every cycle in this priority order:
//   1. done=1 -> REL. No timeout pulse.
//   2. req[gnt_idx]=0 (request dropped) -> REL. No timeout pulse.
//   3. hold_cnt==MAX_HOLD-1 -> REL, and timeout=1 in the next cycle.
//   The grant therefore lasts at most MAX_HOLD cycles.
//  REL (1 cycle):
//   - gnt=0, gnt_valid=0, busy=1.
//   - last_idx<=gnt_idx, then go to IDLE.
//   - Guarantees at least 2 dead cycles between grants: the REL cycle and the
//     IDLE arbitration cycle.
//  Fairness:
//   - After a release, the previous owner has lowest priority.
//   - A requester that times out and still requests is re-queued behind the others.
//  Ignored inputs:
//   - done outside GRANT.
//   - req bits from non-owners during GRANT; they are only sampled in IDLE.
//  Boundaries:
//   - Wrap-around: last_idx=7 scans 0,1,...,7. Only req[7] set with last_idx=7
//     re-grants 7.
//   - done and timeout condition in the same cycle: done wins, timeout stays 0.
//  Reset mid-GRANT: gnt drops asynchronously and priority returns to requester 0.
//  Invariant: gnt == (gnt_valid ? 8'b1<<gnt_idx : 8'b0) in every cycle.
// STRUCTURE
//  Shared package rr_arb_pkg:
//   - state encoding IDLE=2'd0, GRANT=2'd1, REL=2'd2.
//   - N_REQ, IDX_W, CNT_W constants.
//  One sub-module, rr_pick_next: combinational rotate-priority picker.
//   - Inputs: req[7:0], last_idx[2:0].
//   - Outputs: next_idx[2:0], any_req.
//  Top level: FSM, hold counter, registers, and one decoder_3x8 instance.
// TESTING
//  1. Reset, then req=8'h01 -> next cycle gnt=8'h01, gnt_idx=0.
//     done pulse -> one REL cycle with gnt=0 -> IDLE.
//  2. req=8'hFF held, done after 1 grant cycle each -> gnt_idx sequence
//     0,1,...,7,0 (wrap-around), 3-cycle period per grant.
//  3. req=8'h24, owner never sends done, MAX_HOLD=12 -> gnt=8'h04 for exactly
//     12 cycles, timeout=1 for 1 cycle, next grant gnt=8'h20.
//  4. done asserted on the 12th grant cycle together with the timeout condition
//     -> release with timeout=0.
//  5. Grant to requester 5, then req[5] dropped mid-grant -> gnt=0 next cycle,
//     no timeout.
//  6. rst_n=0 mid-GRANT on index 6 -> outputs 0 immediately.
//     After release, req=8'hC1 -> gnt=8'h01, priority restarts at 0.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared constants and FSM state encoding for the round-robin arbiter.
package rr_arb_pkg;
    localparam int N_REQ = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 4;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_REL   = 2'd2;
endpackage

// File: rtl/decoder_3x8.sv
// decoder_3x8: enabled 3-to-8 one-hot decoder.
module decoder_3x8 (
    input  logic [2:0] i_a,
    input  logic       i_en,
    output logic [7:0] o_y
);
    assign o_y = i_en ? 8'b1 << i_a : 8'b0;
endmodule

// File: rtl/rr_pick_next.sv
// rr_pick_next: rotating-priority picker, first set request after i_last_idx wins.
module rr_pick_next
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last_idx,
    output logic [IDX_W-1:0] o_next_idx,
    output logic             o_any_req
);
    logic [IDX_W-1:0] w_cand;
    assign o_any_req = |i_req;
    // Scan farthest offset first so the nearest set bit overwrites; offset 8 wraps to last_idx itself.
    always_comb begin
        o_next_idx = i_last_idx;
        w_cand     = i_last_idx;
        for (int k = N_REQ; k >= 1; k--) begin
            w_cand = i_last_idx + IDX_W'(k);
            if (i_req[w_cand]) o_next_idx = w_cand;
        end
    end
endmodule

// File: rtl/rr_decoder_arbiter.sv
// rr_decoder_arbiter: 8-way round-robin arbiter with hold timeout; one-hot grant
// is decoded from the registered owner index.
module rr_decoder_arbiter
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout,
    output logic             busy
);
    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_last;
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;
    logic [IDX_W-1:0] w_next_idx;
    logic             w_any_req;
    logic             w_hold_end;

    rr_pick_next u_pick (
        .i_req      (req),
        .i_last_idx (r_last),
        .o_next_idx (w_next_idx),
        .o_any_req  (w_any_req)
    );

    decoder_3x8 u_dec (
        .i_a  (r_idx),
        .i_en (gnt_valid),
        .o_y  (gnt)
    );

    assign gnt_valid  = r_state == S_GRANT;
    assign busy       = r_state != S_IDLE;
    assign gnt_idx    = r_idx;
    assign timeout    = r_timeout;
    assign w_hold_end = r_cnt == CNT_W'(MAX_HOLD - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_last    <= IDX_W'(N_REQ - 1);
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: if (w_any_req) begin
                    r_idx   <= w_next_idx;
                    r_cnt   <= '0;
                    r_state <= S_GRANT;
                end
                S_GRANT: begin
                    if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
                    if (done || !req[r_idx] || w_hold_end) r_state <= S_REL;
                    // Timeout only when neither done nor a dropped request released first.
                    r_timeout <= !done && req[r_idx] && w_hold_end;
                end
                S_REL: begin
                    r_last  <= r_idx;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
